dp_mem: RTL and testbench

//  Dual-port synchronous RAM: two independent request ports (A, B) sharing one clock.

---
 rtl/dp_mem.sv | 122 ++++++++++++
 tb/tb_dp_mem.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dp_mem.sv
// dp_mem: dual-port flop-array RAM, two independent valid/ready request ports on one clock.
// Latency: one cycle from acceptance to ready; read data arrives with ready.
// Backpressure: each port accepts at most every second cycle; valid is ignored while a response is out.
// Ports:
//    clk, rstn                       clock, async active-low reset (clears memory and outputs)
//    addr_x, wr_data_x, op_x         request for port x (op: 1=write, 0=read)
//    valid_x / ready_x               request held until ready_x; ready_x is a one-cycle completion pulse
//    rd_data_x                       read data; held until the next read completes on that port
module dp_mem #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wr_data_a,
   input  logic              op_a,
   input  logic              valid_a,
   output logic              ready_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wr_data_b,
   input  logic              op_b,
   input  logic              valid_b,
   output logic              ready_b,
   output logic [DATA_W-1:0] rd_data_b
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {IDLE, RESP} state_t;

   state_t            state_a, state_b;
   logic [DATA_W-1:0] mem [DEPTH];

   logic accept_a, accept_b;

   assign accept_a = (state_a == IDLE) && valid_a;
   assign accept_b = (state_b == IDLE) && valid_b;

   // Storage. Port B is written first so that port A wins a same-address
   // write/write collision. Reads in the port blocks below sample the array
   // before these updates land, which gives read-before-write on collisions.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (accept_b && op_b) begin
            mem[addr_b] <= wr_data_b;
         end
         if (accept_a && op_a) begin
            mem[addr_a] <= wr_data_a;
         end
      end
   end

   // Port A request FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_a   <= IDLE;
         ready_a   <= 1'b0;
         rd_data_a <= '0;
      end else begin
         case (state_a)
            IDLE: begin
               if (valid_a) begin
                  state_a <= RESP;
                  ready_a <= 1'b1;
                  if (!op_a) begin
                     rd_data_a <= mem[addr_a];
                  end
               end else begin
                  ready_a <= 1'b0;
               end
            end
            RESP: begin
               // Completion cycle: a still-held request is taken on the next IDLE edge.
               state_a <= IDLE;
               ready_a <= 1'b0;
            end
            default: begin
               state_a <= IDLE;
               ready_a <= 1'b0;
            end
         endcase
      end
   end

   // Port B request FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_b   <= IDLE;
         ready_b   <= 1'b0;
         rd_data_b <= '0;
      end else begin
         case (state_b)
            IDLE: begin
               if (valid_b) begin
                  state_b <= RESP;
                  ready_b <= 1'b1;
                  if (!op_b) begin
                     rd_data_b <= mem[addr_b];
                  end
               end else begin
                  ready_b <= 1'b0;
               end
            end
            RESP: begin
               state_b <= IDLE;
               ready_b <= 1'b0;
            end
            default: begin
               state_b <= IDLE;
               ready_b <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dp_mem.sv
// tb_dp_mem: directed and random bench for dp_mem against an array reference model.
// Inputs change and outputs are sampled on the falling edge.
// Ports are driven one transaction at a time; port B also streams with valid held.
module tb_dp_mem;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [AW-1:0] addr_a = '0, addr_b = '0;
   logic [DW-1:0] wr_data_a = '0, wr_data_b = '0;
   logic          op_a = 1'b0, op_b = 1'b0;
   logic          valid_a = 1'b0, valid_b = 1'b0;
   logic          ready_a, ready_b;
   logic [DW-1:0] rd_data_a, rd_data_b;

   always #5 clk = ~clk;

   dp_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .addr_a    (addr_a),
      .wr_data_a (wr_data_a),
      .op_a      (op_a),
      .valid_a   (valid_a),
      .ready_a   (ready_a),
      .rd_data_a (rd_data_a),
      .addr_b    (addr_b),
      .wr_data_b (wr_data_b),
      .op_b      (op_b),
      .valid_b   (valid_b),
      .ready_b   (ready_b),
      .rd_data_b (rd_data_b)
   );

   // Reference model: plain array of words plus the last value read on each port.
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] exp_rd_a, exp_rd_b;
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      exp_rd_a = '0;
      exp_rd_b = '0;
   endtask

   // One transaction on either or both ports, issued from a falling edge with
   // both ports idle. Ends on a falling edge with both ports idle again.
   task automatic txn(input string tag,
                      input logic va, input logic oa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic vb, input logic ob, input logic [AW-1:0] ab, input logic [DW-1:0] db);
      valid_a = va; op_a = oa; addr_a = aa; wr_data_a = da;
      valid_b = vb; op_b = ob; addr_b = ab; wr_data_b = db;
      // Both reads observe the memory as it was before this edge's writes.
      if (va && !oa) exp_rd_a = ref_mem[aa];
      if (vb && !ob) exp_rd_b = ref_mem[ab];
      // Port A's write is applied last: it wins a same-address collision.
      if (vb && ob) ref_mem[ab] = db;
      if (va && oa) ref_mem[aa] = da;
      @(negedge clk);
      check({tag, "/ready_a"}, ready_a, va);
      check({tag, "/ready_b"}, ready_b, vb);
      check({tag, "/rd_data_a"}, rd_data_a, exp_rd_a);
      check({tag, "/rd_data_b"}, rd_data_b, exp_rd_b);
      valid_a = 1'b0;
      valid_b = 1'b0;
      @(negedge clk);
      check({tag, "/ready_a_low"}, ready_a, 1'b0);
      check({tag, "/ready_b_low"}, ready_b, 1'b0);
   endtask

   initial begin
      int n;
      logic va, vb, oa, ob;
      logic [AW-1:0] aa, ab;

      // Reset state
      model_reset();
      repeat (2) @(negedge clk);
      check("reset/ready_a", ready_a, 1'b0);
      check("reset/ready_b", ready_b, 1'b0);
      check("reset/rd_data_a", rd_data_a, '0);
      check("reset/rd_data_b", rd_data_b, '0);
      rstn = 1'b1;
      @(negedge clk);

      // 1: read of a cleared location
      txn("t1_read", 1, 0, 8'h10, '0, 0, 0, '0, '0);

      // 2: A writes, B reads it back
      txn("t2_wr", 1, 1, 8'h05, 32'hDEADBEEF, 0, 0, '0, '0);
      txn("t2_rd", 0, 0, '0, '0, 1, 0, 8'h05, '0);
      check("t2_value", rd_data_b, 32'hDEADBEEF);

      // 3: same-edge write/write, port A data survives
      txn("t3_ww", 1, 1, 8'h20, 32'h11111111, 1, 1, 8'h20, 32'h22222222);
      txn("t3_rd", 1, 0, 8'h20, '0, 1, 0, 8'h20, '0);
      check("t3_value", rd_data_a, 32'h11111111);

      // 4: same-edge write/read returns the old word, later read the new one
      txn("t4_wr", 1, 1, 8'h30, 32'hAAAA5555, 1, 0, 8'h30, '0);
      check("t4_old", rd_data_b, 32'h0);
      txn("t4_rd", 0, 0, '0, '0, 1, 0, 8'h30, '0);
      check("t4_new", rd_data_b, 32'hAAAA5555);

      // 5: A fills all locations with data = address
      for (int i = 0; i < 256; i++) begin
         txn("t5_fill", 1, 1, AW'(i), DW'(i), 0, 0, '0, '0);
      end
      // B streams reads with valid held; ready should arrive every second cycle
      valid_b = 1'b1;
      op_b = 1'b0;
      for (int i = 0; i < 256; i++) begin
         addr_b = AW'(i);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!ready_b && n < 4);
         check("t5_ready", ready_b, 1'b1);
         check("t5_spacing", n, (i == 0) ? 1 : 2);
         check("t5_data", rd_data_b, DW'(i));
         exp_rd_b = DW'(i);
      end
      valid_b = 1'b0;
      @(negedge clk);
      check("t5_idle", ready_b, 1'b0);

      // 6: reset while a write is in flight
      valid_a = 1'b1; op_a = 1'b1; addr_a = 8'h40; wr_data_a = 32'h1234;
      @(posedge clk);
      #2;
      rstn = 1'b0;
      valid_a = 1'b0;
      model_reset();
      @(negedge clk);
      check("t6_rst_ready_a", ready_a, 1'b0);
      check("t6_rst_ready_b", ready_b, 1'b0);
      check("t6_rst_rd_a", rd_data_a, '0);
      check("t6_rst_rd_b", rd_data_b, '0);
      @(negedge clk);
      check("t6_rst_ready_a2", ready_a, 1'b0);
      rstn = 1'b1;
      @(negedge clk);
      check("t6_post_ready_a", ready_a, 1'b0);
      txn("t6_rd", 1, 0, 8'h40, '0, 0, 0, '0, '0);
      txn("t6_rd_ff", 0, 0, '0, '0, 1, 0, 8'hFF, '0);

      // Random traffic on both ports, addresses biased to collide
      for (int k = 0; k < 300; k++) begin
         va = 1'($urandom_range(0, 1));
         vb = 1'($urandom_range(0, 1));
         oa = 1'($urandom_range(0, 1));
         ob = 1'($urandom_range(0, 1));
         aa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         ab = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         txn("rand", va, oa, aa, DW'($urandom), vb, ob, ab, DW'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
